// File: rtl/uart_rx_sampler_if.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler_if
//   Bundle between the UART serial line, the receive sampler and the RX FIFO
//   write side.
//
//   Handshake: data_valid is a one-cycle push strobe with no ready/back-pressure.
//   data_out is meaningful in the cycle data_valid is high and holds the last
//   good byte afterwards. frame_error (and parity_error when built with
//   UART_RX_PARITY_EN) are one-cycle strobes. data_valid and frame_error are
//   never high together.
//
//   Signals:
//     rx           serial line into the sampler (idle high, asynchronous)
//     data_out     last correctly framed byte
//     data_valid   one-cycle strobe, data_out updated this cycle
//     frame_error  one-cycle strobe, stop bit sampled low
//     busy         sampler is not idle
//     state        debug view of the receive FSM state
//     parity_error one-cycle strobe alongside data_valid (UART_RX_PARITY_EN only)
//
//   Modports: master = sampler side, slave = line driver / FIFO side.
// ----------------------------------------------------------------------------
interface uart_rx_sampler_if #(
    parameter int width = 8
) ();
    logic             rx;
    logic [width-1:0] data_out;
    logic             data_valid;
    logic             frame_error;
    logic             busy;
    logic [2:0]       state;
`ifdef UART_RX_PARITY_EN
    logic             parity_error;
`endif

    modport master (
        input  rx,
        output data_out, data_valid, frame_error, busy, state
`ifdef UART_RX_PARITY_EN
        , output parity_error
`endif
    );

    modport slave (
        output rx,
        input  data_out, data_valid, frame_error, busy, state
`ifdef UART_RX_PARITY_EN
        , input parity_error
`endif
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
//   Serial receive front end of the buffered UART. Synchronises rx, finds the
//   start bit, samples each bit near its centre and pushes one byte per frame
//   to the RX FIFO as a single-cycle data_valid strobe. A low stop bit gives a
//   single frame_error strobe; a held-low line (break) is waited out.
//
//   Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
//   between the last data bit and the stop bit and to drive bus.parity_error.
//
//   Ports:
//     clock   system clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     uart_rx_sampler_if.master (rx, data_out, data_valid,
//             frame_error, busy, state [, parity_error])
// ----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int width      = 8,
    parameter int baud_rate  = 9600,
    parameter int clock_freq = 460800
) (
    input  logic                  clock,
    input  logic                  resetn,
    uart_rx_sampler_if.master     bus
);
    localparam int CYCLES_PER_BIT = clock_freq / baud_rate;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT);
    localparam int BW             = (width > 1) ? $clog2(width) : 1;

    localparam logic [CW-1:0] BIT_LAST     = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_BIT - 1);
    localparam logic [BW-1:0] BIT_CNT_LAST = BW'(width - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    // The bit timing only works for an exact integer divisor of at least 4.
    if ((clock_freq % baud_rate) != 0 || CYCLES_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx_sampler: clock_freq/baud_rate must be exact and >= 4");
    end

    logic             rx_q1;
    logic             rx_s;
    logic [2:0]       state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [width-1:0] shift_reg;
    logic [width-1:0] data_out;
    logic             data_valid;
    logic             frame_error;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad;
    logic             parity_error;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_q1       <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            rx_q1       <= bus.rx;
            rx_s        <= rx_q1;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        cyc_cnt <= '0;
                    end
                end
                START: begin
                    // Re-check the line mid start bit to reject short glitches.
                    if (cyc_cnt == HALF_LAST) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt   <= '0;
                        // LSB arrives first, so shift right and fill from the top.
                        shift_reg <= {rx_s, shift_reg[width-1:1]};
                        if (bit_cnt == BIT_CNT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt    <= '0;
                        // Even parity: data ones plus parity bit must be even.
                        parity_bad <= rx_s ^ (^shift_reg);
                        state      <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    // Leaving here mid stop bit lets a directly following start
                    // bit be seen by IDLE.
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (rx_s) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error <= parity_bad;
`endif
                            state      <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    // Hold here so a long low line yields one error, not frames.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = data_out;
    assign bus.data_valid  = data_valid;
    assign bus.frame_error = frame_error;
    assign bus.busy        = (state != IDLE);
    assign bus.state       = state;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = parity_error;
`endif
endmodule
